teak_action_control: RTL
========================

# teak_action_control

Host-facing control block for a kernel action. Terminates the 32-bit AXI-Lite control slave, holds a run-control/status register and a parameter register file, and sequences one action run through the go/done handshake. Serves parameter words to the action over the param_addr/param_data channel pair. Sits between the host control bus and the action top level (`teak_action_top_gmem`).

## Interface
- PARAM_COUNT, 16: number of 32-bit parameter registers (1..64)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axi_araddr/arcache/arprot/arvalid  in  32/4/3/1  read address (cache, prot ignored)
- s_axi_arready  out  1  read address accept
- s_axi_rdata/rresp/rvalid  out  32/2/1  read data, rresp always 2'b00
- s_axi_rready  in  1  read data accept
- s_axi_awaddr/awcache/awprot/awvalid  in  32/4/3/1  write address (cache, prot ignored)
- s_axi_awready  out  1  write address accept
- s_axi_wdata/wstrb/wvalid  in  32/4/1  write data and byte strobes
- s_axi_wready  out  1  write data accept
- s_axi_bresp/bvalid  out  2/1  write response, bresp always 2'b00
- s_axi_bready  in  1  write response accept
- go_0r  out  1  start request to action
- go_0a  in  1  start acknowledge
- done_0r  in  1  completion request from action
- done_0a  out  1  completion acknowledge
- param_addr_0r  in  1  parameter index request
- param_addr  in  32  parameter word index
- param_addr_0a  out  1  parameter index acknowledge
- param_data_0r  out  1  parameter data valid
- param_data  out  32  parameter word
- param_data_0a  in  1  parameter data acknowledge
- irq  out  1  completion interrupt (only with TEAK_ACTION_CTRL_IRQ_EN)

## Operation
- Register map, decoded on address bits [9:2], higher bits ignored:
  - 0x00 CTRL: bit0 start (write 1 to set; reads 1 in GO/RUN/ACK/DRAIN), bit1 done (sticky, cleared by a read of 0x00), bit2 idle (1 in IDLE).
  - 0x04 GIE, 0x0C ISR: interrupt registers, see Configuration.
  - 0x10 + 4*i: PARAM[i], i < PARAM_COUNT, read/write, byte-masked by wstrb.
- Unmapped reads return 0. Unmapped writes are dropped. Every response is OKAY.
- PARAM writes are dropped while CTRL.idle = 0. Writing start=1 while not idle is ignored.
- Sequencer FSM:
  - IDLE: a start write moves to GO.
  - GO: go_0r=1. On go_0a=1, drop go_0r. If done_0r=1 is sampled in the same cycle, go to ACK; otherwise go to RUN.
  - RUN: on done_0r=1, go to ACK.
  - ACK: done_0a=1 for exactly one cycle, then go to DRAIN.
  - DRAIN: on done_0r=0, go to IDLE, set CTRL.done and ISR[0].
- Parameter FSM:
  - P_IDLE: on param_addr_0r=1, latch PARAM[param_addr] (0 if param_addr >= PARAM_COUNT) and go to P_DATA.
  - P_DATA: param_addr_0a=1 and param_data_0r=1, both held. On param_data_0a=1, go to P_RTZ.
  - P_RTZ: both outputs 0. On param_addr_0r=0, go to P_IDLE.
- AXI read:
  - arready is a one-cycle pulse, issued the cycle after arvalid is sampled, only when no rvalid is outstanding.
  - rvalid rises the cycle after arready and is held until rready is sampled high.
- AXI write:
  - Requires awvalid & wvalid in the same cycle.
  - awready and wready pulse together for one cycle; the register is updated on that cycle.
  - bvalid rises the next cycle and is held until bready is sampled high.
- A simultaneous read and write are serviced independently. The read returns the pre-write value.

## Timing
- Reset values: every output 0, except CTRL.idle = 1. PARAM[*], GIE and ISR = 0. Both FSMs in their idle states. Reset mid-run aborts immediately and drops go_0r/done_0a/param_data_0r the next cycle.
- Start write accept edge -> go_0r high 1 cycle later.
- done_0r first sampled -> done_0a high the next cycle. DRAIN exit -> CTRL.done readable the next cycle.
- param_addr_0r sampled in P_IDLE -> param_data_0r high the next cycle. param_data is stable while param_data_0r = 1.
- AXI read latency: arvalid -> rvalid = 2 cycles. AXI write latency: aw/wvalid -> bvalid = 2 cycles.
- A CTRL read that coincides with the done set returns done = 1 and does not clear it.

## Configuration
- TEAK_ACTION_CTRL_IRQ_EN defined:
  - irq port present, irq = GIE[0] & ISR[0], registered.
  - ISR[0] is set on completion and cleared by writing 1 to ISR bit 0 (toggle-on-write).
- TEAK_ACTION_CTRL_IRQ_EN undefined:
  - irq port absent.
  - 0x04 and 0x0C read 0; writes to them are dropped.

## Test plan
- Reset, then read 0x00 -> rdata = 0x4, with rvalid 2 cycles after arvalid.
- Write PARAM[3] = 0xDEADBEEF (wstrb 4'hF), then write 0x00 = 1. Action drives param_addr = 3 -> param_data = 0xDEADBEEF. Read of 0x00 -> 0x1.
- Action returns go_0a and done_0r in the same cycle -> single done_0a pulse, CTRL reads 0x6 then 0x4 on the second read.
- param_addr = 70 with PARAM_COUNT = 16 -> param_data = 0. Write to PARAM[0] while busy -> readback unchanged.
- IRQ build: GIE = 1, run to completion -> irq = 1. Write ISR = 1 -> irq = 0 the next cycle.
- Assert reset while in RUN -> go_0r and done_0a = 0, CTRL = 0x4, a new start runs normally.

Source files
------------

// File: rtl/teak_action_control.sv
// Host control block for a kernel action: AXI-Lite slave, CTRL/param registers, go/done sequencer
// and param_addr/param_data server. Optional interrupt logic under TEAK_ACTION_CTRL_IRQ_EN.
module teak_action_control #(
   parameter int PARAM_COUNT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] s_axi_araddr,
   input  logic [3:0]  s_axi_arcache,
   input  logic [2:0]  s_axi_arprot,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   input  logic [31:0] s_axi_awaddr,
   input  logic [3:0]  s_axi_awcache,
   input  logic [2:0]  s_axi_awprot,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   output logic        go_0r,
   input  logic        go_0a,
   input  logic        done_0r,
   output logic        done_0a,
   input  logic        param_addr_0r,
   input  logic [31:0] param_addr,
   output logic        param_addr_0a,
   output logic        param_data_0r,
   output logic [31:0] param_data,
   input  logic        param_data_0a
`ifdef TEAK_ACTION_CTRL_IRQ_EN
   ,output logic       irq
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_GO, S_RUN, S_ACK, S_DRAIN} seq_t;
   typedef enum logic [1:0] {P_IDLE, P_DATA, P_RTZ} par_t;

   localparam logic [7:0] A_CTRL = 8'h00;
`ifdef TEAK_ACTION_CTRL_IRQ_EN
   localparam logic [7:0] A_GIE  = 8'h01;
   localparam logic [7:0] A_ISR  = 8'h03;
`endif

   seq_t        seq_q;
   par_t        par_q;
   logic        go_q, done_a_q;
   logic        pa_a_q, pd_r_q;
   logic [31:0] pdata_q;

   logic        arready_q, rvalid_q, awready_q, bvalid_q;
   logic [31:0] rdata_q;
   logic        done_q, done_d;
   logic [31:0] param_q [PARAM_COUNT];
   logic [31:0] param_d [PARAM_COUNT];

   logic        rd_fire, wr_fire, seq_idle, done_set, start_wr;
   logic [7:0]  rd_idx, wr_idx;
   logic [31:0] rd_val, pmux;

`ifdef TEAK_ACTION_CTRL_IRQ_EN
   logic gie_q, gie_d, isr_q, isr_d, irq_q;
`endif

   logic unused_ok;
   assign unused_ok = ^{s_axi_araddr[31:10], s_axi_araddr[1:0], s_axi_awaddr[31:10],
                        s_axi_awaddr[1:0], s_axi_arcache, s_axi_arprot, s_axi_awcache,
                        s_axi_awprot};

   assign rd_idx   = s_axi_araddr[9:2];
   assign wr_idx   = s_axi_awaddr[9:2];
   assign rd_fire  = s_axi_arvalid & arready_q;
   assign wr_fire  = s_axi_awvalid & s_axi_wvalid & awready_q;
   assign seq_idle = (seq_q == S_IDLE);
   assign done_set = (seq_q == S_DRAIN) & ~done_0r;
   assign start_wr = wr_fire & (wr_idx == A_CTRL) & s_axi_wstrb[0] & s_axi_wdata[0] & seq_idle;

   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = 2'b00;
   assign s_axi_awready = awready_q;
   assign s_axi_wready  = awready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = 2'b00;
   assign go_0r         = go_q;
   assign done_0a       = done_a_q;
   assign param_addr_0a = pa_a_q;
   assign param_data_0r = pd_r_q;
   assign param_data    = pdata_q;

   // A read landing on the done-set edge must already see done=1.
   always_comb begin
      rd_val = '0;
      if (rd_idx == A_CTRL)
         rd_val = {29'b0, seq_idle, done_q | done_set, ~seq_idle};
`ifdef TEAK_ACTION_CTRL_IRQ_EN
      if (rd_idx == A_GIE) rd_val = {31'b0, gie_q};
      if (rd_idx == A_ISR) rd_val = {31'b0, isr_q};
`endif
      for (int i = 0; i < PARAM_COUNT; i++)
         if (rd_idx == 8'(i + 4)) rd_val = param_q[i];
   end

   always_comb begin
      param_d = param_q;
      if (wr_fire && seq_idle)
         for (int i = 0; i < PARAM_COUNT; i++)
            if (wr_idx == 8'(i + 4))
               for (int b = 0; b < 4; b++)
                  if (s_axi_wstrb[b]) param_d[i][8*b +: 8] = s_axi_wdata[8*b +: 8];
   end

   always_comb begin
      done_d = done_q;
      if (rd_fire && rd_idx == A_CTRL) done_d = 1'b0;
      if (done_set) done_d = 1'b1;
   end

`ifdef TEAK_ACTION_CTRL_IRQ_EN
   always_comb begin
      gie_d = gie_q;
      isr_d = isr_q;
      if (wr_fire && wr_idx == A_GIE && s_axi_wstrb[0]) gie_d = s_axi_wdata[0];
      if (wr_fire && wr_idx == A_ISR && s_axi_wstrb[0] && s_axi_wdata[0]) isr_d = 1'b0;
      if (done_set) isr_d = 1'b1;
   end

   // Built from next-state values so irq follows an ISR clear on the very next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         gie_q <= 1'b0;
         isr_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         gie_q <= gie_d;
         isr_q <= isr_d;
         irq_q <= gie_d & isr_d;
      end
   end

   assign irq = irq_q;
`endif

   always_comb begin
      pmux = '0;
      for (int i = 0; i < PARAM_COUNT; i++)
         if (param_addr == 32'(i)) pmux = param_q[i];
   end

   // AXI-Lite channels and register file
   always_ff @(posedge clk) begin
      if (reset) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         done_q    <= 1'b0;
         for (int i = 0; i < PARAM_COUNT; i++) param_q[i] <= '0;
      end else begin
         arready_q <= s_axi_arvalid & ~arready_q & ~rvalid_q;
         if (rd_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
         end else if (rvalid_q && s_axi_rready) begin
            rvalid_q <= 1'b0;
         end
         awready_q <= s_axi_awvalid & s_axi_wvalid & ~awready_q & ~bvalid_q;
         if (wr_fire)
            bvalid_q <= 1'b1;
         else if (bvalid_q && s_axi_bready)
            bvalid_q <= 1'b0;
         done_q  <= done_d;
         param_q <= param_d;
      end
   end

   // Run sequencer
   always_ff @(posedge clk) begin
      if (reset) begin
         seq_q    <= S_IDLE;
         go_q     <= 1'b0;
         done_a_q <= 1'b0;
      end else begin
         case (seq_q)
            S_IDLE: if (start_wr) begin
               seq_q <= S_GO;
               go_q  <= 1'b1;
            end
            S_GO: if (go_0a) begin
               go_q <= 1'b0;
               if (done_0r) begin
                  seq_q    <= S_ACK;
                  done_a_q <= 1'b1;
               end else begin
                  seq_q <= S_RUN;
               end
            end
            S_RUN: if (done_0r) begin
               seq_q    <= S_ACK;
               done_a_q <= 1'b1;
            end
            S_ACK: begin
               seq_q    <= S_DRAIN;
               done_a_q <= 1'b0;
            end
            S_DRAIN: if (!done_0r) seq_q <= S_IDLE;
            default: begin
               seq_q    <= S_IDLE;
               go_q     <= 1'b0;
               done_a_q <= 1'b0;
            end
         endcase
      end
   end

   // Parameter server: four-phase handshake, data latched once per request
   always_ff @(posedge clk) begin
      if (reset) begin
         par_q   <= P_IDLE;
         pa_a_q  <= 1'b0;
         pd_r_q  <= 1'b0;
         pdata_q <= '0;
      end else begin
         case (par_q)
            P_IDLE: if (param_addr_0r) begin
               par_q   <= P_DATA;
               pdata_q <= pmux;
               pa_a_q  <= 1'b1;
               pd_r_q  <= 1'b1;
            end
            P_DATA: if (param_data_0a) begin
               par_q  <= P_RTZ;
               pa_a_q <= 1'b0;
               pd_r_q <= 1'b0;
            end
            P_RTZ: if (!param_addr_0r) par_q <= P_IDLE;
            default: begin
               par_q  <= P_IDLE;
               pa_a_q <= 1'b0;
               pd_r_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
